// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit port: FSM state encoding,
// status-word bit positions and a helper that packs the status flags.
package uart_pkg;

   // Transmit FSM states, one per segment of an 8N1 frame plus idle.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

   // Bit positions inside the CPU-readable status word.
   localparam int STATUS_BUSY_BIT = 0;
   localparam int STATUS_FULL_BIT = 1;
   localparam int STATUS_OVF_BIT  = 2;

   // Index of the last data bit of a frame (eight data bits, LSB first).
   localparam logic [2:0] LAST_DATA_BIT = 3'd7;

   // Places the three flags at their status-word positions.
   function automatic logic [2:0] pack_status(input logic busy,
                                              input logic full,
                                              input logic ovf);
      logic [2:0] s;
      s                  = 3'b000;
      s[STATUS_BUSY_BIT] = busy;
      s[STATUS_FULL_BIT] = full;
      s[STATUS_OVF_BIT]  = ovf;
      return s;
   endfunction

endpackage

// File: rtl/uart_tx_port_if.sv
// CPU-side bus of the UART transmit port: store strobe/data in, serial
// line and status flags out.
interface uart_tx_port_if #(
   parameter int WORD_LENGTH = 32
) ();

   logic                   enableUART;
   logic [WORD_LENGTH-1:0] UART;
   logic                   tx;
   logic                   busy;
   logic                   fifo_full;
   logic                   overflow;
   logic [WORD_LENGTH-1:0] status;

   // CPU / bench side.
   modport master (
      output enableUART,
      output UART,
      input  tx,
      input  busy,
      input  fifo_full,
      input  overflow,
      input  status
   );

   // UART side.
   modport slave (
      input  enableUART,
      input  UART,
      output tx,
      output busy,
      output fifo_full,
      output overflow,
      output status
   );

endinterface

// File: rtl/tx_fifo.sv
// Byte FIFO feeding the UART transmitter. A push into a full FIFO is only
// taken when a pop happens on the same edge; pointers wrap naturally
// because DEPTH is a power of two.
module tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_pop;
   logic             w_do_push;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == {CW{1'b0}});
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_data    = r_mem[r_rd_ptr];

   // Storage array; contents are only observed while the count says valid.
   always_ff @(posedge clk) begin
      if (w_do_push && reset) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers and occupancy; simultaneous push and pop keeps the count.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_count  <= {CW{1'b0}};
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped UART transmitter: CPU stores are queued in tx_fifo and sent
// as 8N1 frames. Back-to-back frames pop at the STOP edge so the line never
// idles between queued bytes.
module uart_tx_port
   import uart_pkg::*;
#(
   parameter int WORD_LENGTH  = 32,
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4
) (
   input logic            clk,
   input logic            reset,
   uart_tx_port_if.slave  bus
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   tx_state_e     r_state;
   tx_state_e     w_state_next;
   logic [BW-1:0] r_baud;
   logic [BW-1:0] w_baud_next;
   logic [2:0]    r_bit;
   logic [2:0]    w_bit_next;
   logic [7:0]    r_shift;
   logic [7:0]    w_shift_next;
   logic          r_tx;
   logic          w_tx_next;
   logic          r_overflow;
   logic          w_baud_end;
   logic          w_pop;
   logic          w_drop;
   logic [7:0]    w_fifo_data;
   logic          w_full;
   logic          w_empty;
   logic          w_busy;

   tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (bus.enableUART),
      .i_pop   (w_pop),
      .i_data  (bus.UART[7:0]),
      .o_data  (w_fifo_data),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_baud_end = (r_baud == BAUD_LAST);
   assign w_drop     = bus.enableUART && w_full && !w_pop;
   assign w_busy     = (r_state != ST_IDLE) || !w_empty;

   // Next-state, baud/bit counters, shifter and the next line level.
   always_comb begin
      w_state_next = r_state;
      w_baud_next  = r_baud;
      w_bit_next   = r_bit;
      w_shift_next = r_shift;
      w_pop        = 1'b0;
      w_tx_next    = 1'b1;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_shift_next = w_fifo_data;
               w_baud_next  = {BW{1'b0}};
               w_state_next = ST_START;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         ST_START: begin
            if (w_baud_end) begin
               w_baud_next  = {BW{1'b0}};
               w_bit_next   = 3'd0;
               w_state_next = ST_DATA;
            end else begin
               w_baud_next  = r_baud + BW'(1);
            end
         end
         ST_DATA: begin
            if (w_baud_end) begin
               w_baud_next = {BW{1'b0}};
               if (r_bit == LAST_DATA_BIT) begin
                  w_state_next = ST_STOP;
               end else begin
                  w_bit_next   = r_bit + 3'd1;
                  w_shift_next = {1'b0, r_shift[7:1]};
               end
            end else begin
               w_baud_next = r_baud + BW'(1);
            end
         end
         ST_STOP: begin
            if (w_baud_end) begin
               w_baud_next = {BW{1'b0}};
               if (!w_empty) begin
                  // Reload straight into START: no idle gap between frames.
                  w_pop        = 1'b1;
                  w_shift_next = w_fifo_data;
                  w_state_next = ST_START;
               end else begin
                  w_state_next = ST_IDLE;
               end
            end else begin
               w_baud_next = r_baud + BW'(1);
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_baud_next  = {BW{1'b0}};
            w_bit_next   = 3'd0;
         end
      endcase

      // Line level that belongs to the state being entered.
      case (w_state_next)
         ST_START: w_tx_next = 1'b0;
         ST_DATA:  w_tx_next = w_shift_next[0];
         default:  w_tx_next = 1'b1;
      endcase
   end

   // FSM, counters, shifter, registered line and sticky overflow.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_baud     <= {BW{1'b0}};
         r_bit      <= 3'd0;
         r_shift    <= 8'h00;
         r_tx       <= 1'b1;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_baud     <= w_baud_next;
         r_bit      <= w_bit_next;
         r_shift    <= w_shift_next;
         r_tx       <= w_tx_next;
         r_overflow <= r_overflow | w_drop;
      end
   end

   assign bus.tx        = r_tx;
   assign bus.busy      = w_busy;
   assign bus.fifo_full = w_full;
   assign bus.overflow  = r_overflow;
   assign bus.status    = {{(WORD_LENGTH-3){1'b0}},
                           pack_status(w_busy, w_full, r_overflow)};

endmodule

// File: tb/tb_uart_tx_port.sv
// Scoreboard bench for uart_tx_port: accepted bytes are queued as expected
// frames, a line monitor samples tx every cycle and compares whole frames.
// A timeline model (FIFO occupancy + cycles left on the line) predicts
// acceptance, overflow and the status flags.
module tb_uart_tx_port;

   localparam int WL    = 32;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic clk;
   logic rst_n;

   uart_tx_port_if #(.WORD_LENGTH(WL)) bus ();

   uart_tx_port #(
      .WORD_LENGTH  (WL),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int         n_tests = 0;
   int         n_fail  = 0;
   bit         chk_on  = 1'b0;
   int         frames_done = 0;
   logic [7:0] m_q[$];
   logic [7:0] sb_q[$];
   int         m_rem = 0;
   bit         m_ovf = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference timeline: a byte leaves the queue when the line is free or
   // finishing its last cycle; a write is kept unless the queue is full and
   // nothing leaves on that edge.
   task automatic model_step(input bit en, input logic [31:0] d, input bit rst);
      int sz;
      bit pop;
      if (!rst) begin
         m_q.delete();
         sb_q.delete();
         m_rem = 0;
         m_ovf = 1'b0;
      end else begin
         sz  = m_q.size();
         pop = (sz > 0) && (m_rem <= 1);
         if (pop) begin
            void'(m_q.pop_front());
            m_rem = FRAME;
         end else if (m_rem > 0) begin
            m_rem--;
         end
         if (en) begin
            if (sz < DEPTH || pop) begin
               m_q.push_back(d[7:0]);
               sb_q.push_back(d[7:0]);
            end else begin
               m_ovf = 1'b1;
            end
         end
      end
   endtask

   function automatic bit m_busy();
      return (m_rem > 0) || (m_q.size() > 0);
   endfunction

   // One clock: inputs applied, edge, model advanced, flags compared at negedge.
   task automatic cyc(input bit en, input logic [31:0] d, input bit rst);
      bit full;
      bus.enableUART = en;
      bus.UART       = d;
      rst_n          = rst;
      @(posedge clk);
      model_step(en, d, rst);
      @(negedge clk);
      if (chk_on) begin
         full = (m_q.size() == DEPTH);
         check("flags", {bus.overflow, bus.fifo_full, bus.busy, bus.status},
               {m_ovf, full, m_busy(), 29'd0, m_ovf, full, m_busy()});
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 1'b1);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (m_busy() && guard < 400) begin
         cyc(1'b0, 32'd0, 1'b1);
         guard++;
      end
      check("drain_in_time", {63'd0, m_busy()}, 64'd0);
      idle(3);
   endtask

   task automatic do_reset();
      cyc(1'b0, 32'd0, 1'b0);
      cyc(1'b0, 32'd0, 1'b0);
   endtask

   // Line monitor: on a start bit, capture 40 cycles and compare against the
   // ideal waveform of the oldest accepted byte.
   initial begin
      logic [39:0] act;
      logic [39:0] exp;
      logic [7:0]  b;
      bit          aborted;
      bit          have;
      forever begin
         @(negedge clk);
         if (chk_on && rst_n === 1'b1 && bus.tx === 1'b0) begin
            have = (sb_q.size() > 0);
            if (!have) begin
               check("unexpected_frame", 64'd1, 64'd0);
               b = 8'h00;
            end else begin
               b = sb_q.pop_front();
            end
            for (int k = 0; k < 40; k++) begin
               if (k < CPB)            exp[k] = 1'b0;
               else if (k >= 9 * CPB)  exp[k] = 1'b1;
               else                    exp[k] = b[(k - CPB) / CPB];
            end
            act     = '0;
            act[0]  = bus.tx;
            aborted = 1'b0;
            for (int k = 1; k < 40; k++) begin
               @(negedge clk);
               if (rst_n !== 1'b1) begin
                  aborted = 1'b1;
                  break;
               end
               act[k] = bus.tx;
            end
            if (!aborted && have) begin
               frames_done++;
               check("frame", {24'd0, act}, {24'd0, exp});
            end
         end
      end
   end

   initial begin
      int f0;
      int guard;
      bus.enableUART = 1'b0;
      bus.UART       = '0;
      rst_n          = 1'b0;
      do_reset();
      chk_on = 1'b1;
      check("reset_tx", {63'd0, bus.tx}, 64'd1);
      check("reset_status", {32'd0, bus.status}, 64'd0);
      idle(3);

      // Single 0xA5 frame.
      cyc(1'b1, 32'h0000_00A5, 1'b1);
      drain();

      // Two back-to-back frames.
      cyc(1'b1, 32'h0000_0001, 1'b1);
      cyc(1'b1, 32'h0000_0080, 1'b1);
      drain();

      // Six consecutive writes: one in flight, four queued, one dropped.
      f0 = frames_done;
      for (int i = 0; i < 6; i++) cyc(1'b1, 32'h10 + i, 1'b1);
      check("overflow_set", {63'd0, bus.overflow}, 64'd1);
      check("status_ovf_bit", {63'd0, bus.status[2]}, 64'd1);
      drain();
      check("five_frames", frames_done - f0, 64'd5);

      // Write into a full FIFO on the same edge as the STOP->START pop.
      do_reset();
      for (int i = 0; i < 5; i++) cyc(1'b1, 32'h20 + i, 1'b1);
      guard = 0;
      while (!(m_rem == 1 && m_q.size() == DEPTH) && guard < 100) begin
         cyc(1'b0, 32'd0, 1'b1);
         guard++;
      end
      check("reached_stop_edge", guard < 100, 64'd1);
      cyc(1'b1, 32'h0000_00C3, 1'b1);
      check("same_edge_no_ovf", {63'd0, bus.overflow}, 64'd0);
      drain();

      // Reset during data bit 3 of 0xFF.
      cyc(1'b1, 32'h0000_00FF, 1'b1);
      guard = 0;
      while (m_rem != 22 && guard < 100) begin
         cyc(1'b0, 32'd0, 1'b1);
         guard++;
      end
      f0 = frames_done;
      cyc(1'b0, 32'd0, 1'b0);
      check("abort_tx_high", {63'd0, bus.tx}, 64'd1);
      check("abort_busy", {63'd0, bus.busy}, 64'd0);
      check("abort_status", {32'd0, bus.status}, 64'd0);
      idle(60);
      check("no_frame_after_abort", frames_done - f0, 64'd0);

      // Upper store bits ignored.
      cyc(1'b1, 32'h1234_5655, 1'b1);
      drain();

      // Random traffic with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 399) == 0) cyc(1'b0, 32'd0, 1'b0);
         else cyc($urandom_range(0, 11) == 0, $urandom, 1'b1);
      end
      drain();
      check("scoreboard_empty", sb_q.size(), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
